// File: rtl/acc_apb_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_regs_pkg
// Description : Register offsets, bit indices and FSM encoding shared by the
//               accelerometer APB register front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_regs_pkg;

    localparam logic [7:0] c_off_addr   = 8'h00;
    localparam logic [7:0] c_off_wdata  = 8'h04;
    localparam logic [7:0] c_off_cmd    = 8'h08;
    localparam logic [7:0] c_off_status = 8'h0C;
    localparam logic [7:0] c_off_rdata  = 8'h10;
    localparam logic [7:0] c_off_irq_en = 8'h14;

    localparam int c_st_busy    = 0;
    localparam int c_st_wr_ok   = 1;
    localparam int c_st_rd_ok   = 2;
    localparam int c_st_timeout = 3;
    localparam int c_st_done    = 4;

    localparam int c_cmd_wr = 0;
    localparam int c_cmd_rd = 1;

    typedef enum logic [1:0] {
        c_idle    = 2'd0,
        c_pending = 2'd1,
        c_active  = 2'd2
    } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/acc_apb_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : acc_apb_regs_if
// Description : APB3 bus bundle between a CPU master and the register slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface acc_apb_regs_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/acc_cmd_timer.sv
`default_nettype none
// ============================================================================
// Module      : acc_cmd_timer
// Description : Saturating down-counter timing a command from accept to done.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_cmd_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    input  wire logic i_en,
    output logic      o_expired
);

    localparam int             c_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_w-1:0] c_load = c_w'(TIMEOUT_CYCLES - 1);

    logic [c_w-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_load;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - c_w'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/acc_apb_regs.sv
`default_nettype none
// ============================================================================
// Module      : acc_apb_regs
// Description : APB3 register front-end for the accelerometer I2C engine:
//               command latches, transaction tracking, status and interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_apb_regs
    import acc_regs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DEBUG_BUS_SIZE = 4
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    acc_apb_regs_if.slave                  apb,
    output logic [7:0]                     addr,
    output logic [7:0]                     data_wr,
    output logic                           wren_latch,
    output logic                           rden_latch,
    input  wire logic                      wren_clr,
    input  wire logic                      rden_clr,
    input  wire logic [7:0]                data_rd,
    input  wire logic                      rd_ok,
    input  wire logic                      wr_ok,
    input  wire logic                      eng_req,
    output logic                           irq,
    output logic [DEBUG_BUS_SIZE-1:0]      debug
);

    acc_state_t r_state, w_state_next;

    logic [7:0] r_addr, r_wdata, r_rdata;
    logic       r_wren, r_rden, r_op_read;
    logic       r_wr_ok_cap, r_rd_ok_cap, r_timeout, r_done;
    logic       r_irq_en, r_irq;

    logic w_access, w_busy, w_mapped, w_locked, w_err, w_wr;
    logic w_wr_addr, w_wr_wdata, w_wr_cmd, w_wr_status, w_wr_irq_en;
    logic w_accept, w_drop_wr, w_drop_rd, w_set_timeout, w_set_done, w_capture;
    logic w_expired;
    logic [31:0] w_prdata;
    logic w_unused;

    assign w_access = apb.psel & apb.penable;
    assign w_busy   = (r_state != c_idle);

    always_comb begin
        w_mapped = 1'b0;
        w_locked = 1'b0;
        case (apb.paddr)
            c_off_addr, c_off_wdata, c_off_cmd: begin
                w_mapped = 1'b1;
                // Engine samples addr/data_wr mid-transaction, so hold them
                w_locked = apb.pwrite & w_busy;
            end
            c_off_status, c_off_rdata, c_off_irq_en: w_mapped = 1'b1;
            default: ;
        endcase
    end

    assign w_err       = w_access & (~w_mapped | w_locked);
    assign w_wr        = w_access & apb.pwrite & ~w_err;
    assign w_wr_addr   = w_wr & (apb.paddr == c_off_addr);
    assign w_wr_wdata  = w_wr & (apb.paddr == c_off_wdata);
    assign w_wr_cmd    = w_wr & (apb.paddr == c_off_cmd);
    assign w_wr_status = w_wr & (apb.paddr == c_off_status);
    assign w_wr_irq_en = w_wr & (apb.paddr == c_off_irq_en);

    always_comb begin
        w_prdata = '0;
        if (apb.psel && !apb.pwrite) begin
            case (apb.paddr)
                c_off_addr:   w_prdata = {24'd0, r_addr};
                c_off_wdata:  w_prdata = {24'd0, r_wdata};
                c_off_status: w_prdata = {27'd0, r_done, r_timeout, r_rd_ok_cap, r_wr_ok_cap, w_busy};
                c_off_rdata:  w_prdata = {24'd0, r_rdata};
                c_off_irq_en: w_prdata = {31'd0, r_irq_en};
                default:      w_prdata = '0;
            endcase
        end
    end

    assign apb.prdata  = w_prdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_drop_wr     = 1'b0;
        w_drop_rd     = 1'b0;
        w_set_timeout = 1'b0;
        w_set_done    = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_wr_cmd && (apb.pwdata[c_cmd_wr] || apb.pwdata[c_cmd_rd])) begin
                    w_accept     = 1'b1;
                    w_state_next = c_pending;
                end
            end
            c_pending: begin
                if (wren_clr || rden_clr) begin
                    w_drop_wr    = wren_clr;
                    w_drop_rd    = rden_clr;
                    w_state_next = c_active;
                end else if (w_expired) begin
                    w_drop_wr     = 1'b1;
                    w_drop_rd     = 1'b1;
                    w_set_timeout = 1'b1;
                    w_set_done    = 1'b1;
                    w_state_next  = c_idle;
                end
            end
            c_active: begin
                // The engine cannot be aborted: a timeout only flags it
                if (!eng_req) begin
                    w_capture    = 1'b1;
                    w_set_done   = 1'b1;
                    w_state_next = c_idle;
                end else if (w_expired) begin
                    w_set_timeout = 1'b1;
                end
            end
            default: w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_wren      <= 1'b0;
            r_rden      <= 1'b0;
            r_op_read   <= 1'b0;
            r_wr_ok_cap <= 1'b0;
            r_rd_ok_cap <= 1'b0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
            r_irq_en    <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_addr)   r_addr   <= apb.pwdata[7:0];
            if (w_wr_wdata)  r_wdata  <= apb.pwdata[7:0];
            if (w_wr_irq_en) r_irq_en <= apb.pwdata[0];

            if (w_accept) begin
                // Write takes priority when both command bits are set
                r_wren      <= apb.pwdata[c_cmd_wr];
                r_rden      <= ~apb.pwdata[c_cmd_wr] & apb.pwdata[c_cmd_rd];
                r_op_read   <= ~apb.pwdata[c_cmd_wr] & apb.pwdata[c_cmd_rd];
                r_wr_ok_cap <= 1'b0;
                r_rd_ok_cap <= 1'b0;
            end
            if (w_drop_wr) r_wren <= 1'b0;
            if (w_drop_rd) r_rden <= 1'b0;

            if (w_capture) begin
                r_wr_ok_cap <= wr_ok;
                r_rd_ok_cap <= rd_ok;
                if (r_op_read) r_rdata <= data_rd;
            end

            if (w_set_timeout)
                r_timeout <= 1'b1;
            else if (w_wr_status && apb.pwdata[c_st_timeout])
                r_timeout <= 1'b0;

            if (w_set_done)
                r_done <= 1'b1;
            else if (w_accept || (w_wr_status && apb.pwdata[c_st_done]))
                r_done <= 1'b0;

            r_irq <= r_done & r_irq_en;
        end
    end

    acc_cmd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_en      (w_busy),
        .o_expired (w_expired)
    );

    assign addr       = r_addr;
    assign data_wr    = r_wdata;
    assign wren_latch = r_wren;
    assign rden_latch = r_rden;
    assign irq        = r_irq;
    assign debug      = DEBUG_BUS_SIZE'({r_state, r_timeout, w_busy});
    assign w_unused   = ^apb.pwdata[31:8];

endmodule
`default_nettype wire
